// File: rtl/program_loader.sv
// program_loader: fills instruction memory from a serial byte stream.
// Stream format: 4-byte little-endian word count N, then N little-endian
// 32-bit words, written to consecutive word addresses from 0.
module program_loader #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  bad_inst
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned SHIFT_W = 24;
  localparam logic [WORD_W-1:0] CAPACITY = WORD_W'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_LEN  = 2'd0,
    ST_DATA = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]     word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0]     len_q, len_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  bad_q, bad_d;

  // Full field as it would look with the current byte as the top byte.
  logic [WORD_W-1:0] assembled_c;
  logic              last_byte_c;

  assign assembled_c = {rx_data, shift_q};
  assign last_byte_c = (byte_cnt_q == 2'd3);

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LEN;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      bad_q      <= bad_d;
    end
  end

  // Next-state logic: byte assembly, length decode and word writes.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    shift_d    = shift_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    error_d    = error_q;
    bad_d      = bad_q;

    // Lower three bytes of a field collect LSB-first; the fourth is used live.
    if (rx_valid && (state_q == ST_LEN || state_q == ST_DATA)) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    shift_d[7:0]   = rx_data;
        2'd1:    shift_d[15:8]  = rx_data;
        2'd2:    shift_d[23:16] = rx_data;
        default: shift_d        = shift_q;
      endcase
    end

    case (state_q)
      ST_LEN: begin
        if (rx_valid && last_byte_c) begin
          len_d = assembled_c;
          if (assembled_c == '0) begin
            state_d = ST_DONE;
          end else if (assembled_c > CAPACITY) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid && last_byte_c) begin
          wdata_d    = assembled_c;
          addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
          we_d       = 1'b1;
          word_cnt_d = word_cnt_q + WORD_W'(1);
          if (assembled_c[1:0] != 2'b11) begin
            bad_d = 1'b1;
          end
          if (word_cnt_q == len_q - WORD_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (reload) begin
          state_d    = ST_LEN;
          byte_cnt_d = 2'd0;
          word_cnt_d = '0;
          len_d      = '0;
          bad_d      = 1'b0;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_LEN;
      end
    endcase

    busy_d = (state_d == ST_DATA) || (state_d == ST_LEN && byte_cnt_d != 2'd0);
    // Coming from DATA, hold done off for one cycle so it never overlaps the
    // final write strobe.
    done_d = (state_d == ST_DONE) && (state_q != ST_DATA);
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign bad_inst   = bad_q;

endmodule
